scalar_div_sched: RTL
=====================

// Module: scalar_div_sched
// PURPOSE
//  Sequences and shares one scalar_div decode unit between two requesters (two decryption lanes).
//  Arbitrates round-robin, clears the decoder, pulses start, and passes the granted lane's
//  coefficient stream into the decoder in the decoder's fixed STORE window.
//  Returns the N decoded message bits to that lane, tagged with lane id and a last flag.
//  Sits between the lane controllers and the scalar_div instance in the decrypt path.
// PARAMETERS
//  N      1024  coefficients per job; must equal the decoder depth
//  W      30    coefficient width
//  CNT_W  10    log2(N); phase counter is CNT_W+1 bits wide
// PORTS
//  clk         in   1      clock
//  reset       in   1      synchronous, active-low reset (0 = reset)
//  req         in   2      per-lane job request, level
//  grant       out  2      one-hot owner of the decoder, held for the whole job
//  coef_in0    in   W      lane 0 coefficient
//  coef_in1    in   W      lane 1 coefficient
//  coef_vld    in   2      per-lane coefficient valid
//  coef_rdy    out  2      per-lane coefficient ready (granted lane, LOAD only)
//  dec_rst     out  1      decoder reset, active-high
//  dec_start   out  1      decoder start pulse
//  dec_a       out  W      decoder coefficient input
//  dec_msg     in   1      decoder message output
//  msg_valid   out  1      decoded bit valid
//  msg_bit     out  1      decoded bit
//  msg_last    out  1      high with the N-th bit
//  msg_id      out  1      lane that owns msg_bit
//  busy        out  1      high in every state except IDLE
//  err_underrun out 1      sticky: a LOAD cycle saw coef_vld low on the granted lane
// BEHAVIOUR
//  Reset (reset==0 at clk edge):
//   - state=IDLE, counter=0, rr pointer=lane 0.
//   - grant, coef_rdy, dec_start, msg_* , busy, err_underrun all 0.
//   - dec_rst=1 while reset is low.
//   - Reset mid-job aborts the job; no further msg_valid is produced.
//  FSM (s = the DSTART cycle):
//   IDLE    Grant when any req is high. Both high: the lane at rr pointer wins; else the
//           single requester. Set grant next cycle, go to CLEAR.
//   CLEAR   1 cycle, dec_rst=1. This clears the decoder's sticky done. Go to DSTART.
//   DSTART  1 cycle, dec_start=1. Go to LOAD.
//   LOAD    Cycles s+1..s+N; counter counts 0..N-1.
//           - coef_rdy[g]=1; dec_a = coef_in[g] combinationally.
//           - The decoder samples dec_a every cycle, so there is no stall.
//           - coef_vld[g]=0 in any LOAD cycle sets err_underrun; that slot takes dec_a as-is.
//   WAIT    Cycles s+N+1..s+2N+1 (N+1 cycles); this covers the decoder COMPUTE phase
//           plus its output register latency.
//   DRAIN   Cycles s+2N+2..s+3N+1 (N cycles).
//           - msg_valid=1, msg_bit=dec_msg, msg_id=g.
//           - msg_last=1 on the final cycle.
//           - No backpressure: the sink must accept every cycle.
//           - After the last cycle: grant=0, rr pointer = other lane, go to IDLE.
//  Job rules:
//   - Job latency: grant to last bit = 3N+3 cycles; IDLE to next grant is 1 cycle.
//   - req deassert during a job is ignored; the job runs to completion.
//   - A new req is only arbitrated in IDLE.
//   - dec_a=0 and dec_start=0 outside LOAD/DSTART.
//   - err_underrun clears only on reset.
// TESTING
//  1. req=01 alone, coef 0..1023 with t=1000, t_half=500 -> grant=01 after 1 cycle;
//     1024 msg_valid bits matching the golden |a-t|<t_half; msg_last on bit 1023; msg_id=0.
//  2. req=11 held -> jobs granted lane0, lane1, lane0 in turn; msg_id alternates;
//     no overlap of msg_valid between jobs.
//  3. Lane1 drops coef_vld at LOAD index 5 -> err_underrun=1 from the next cycle;
//     the job still emits 1024 bits; err_underrun stays 1 until reset.
//  4. reset=0 for 1 cycle in WAIT -> all outputs 0, dec_rst=1; with req=01 afterwards,
//     a fresh job completes correctly.
//  5. Back-to-back jobs on lane 0 -> CLEAR pulses dec_rst before each dec_start;
//     the second job's bits match golden, proving the decoder's done is cleared.
//  6. req drops to 00 mid-LOAD -> the job completes; grant stays high until after msg_last.

Source files
------------

// File: rtl/scalar_div_sched.sv
// scalar_div_sched
//   Shares one scalar_div decode unit between two decryption lanes. It picks a
//   lane round-robin, clears the decoder, pulses start, and streams the granted
//   lane's N coefficients into the decoder's STORE window. It then waits out
//   the decoder's compute phase and returns the N decoded bits to that lane,
//   tagged with the lane id and a last flag.
// Ports
//   clk, reset        clock; synchronous active-low reset (0 = reset)
//   req[1:0]          per-lane job request (level)
//   grant[1:0]        one-hot decoder owner, held for the whole job
//   coef_in0/1        lane coefficients
//   coef_vld[1:0]     per-lane coefficient valid
//   coef_rdy[1:0]     granted lane ready, LOAD only
//   dec_rst           decoder reset (active-high)
//   dec_start         decoder start pulse
//   dec_a             decoder coefficient input
//   dec_msg           decoder message bit
//   msg_valid/bit/last/id  decoded bit stream back to the lanes
//   busy              high in every state except IDLE
//   err_underrun      sticky: a LOAD slot saw coef_vld low on the granted lane
module scalar_div_sched #(
  parameter int N     = 1024,
  parameter int W     = 30,
  parameter int CNT_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  output logic [1:0]   grant,
  input  logic [W-1:0] coef_in0,
  input  logic [W-1:0] coef_in1,
  input  logic [1:0]   coef_vld,
  output logic [1:0]   coef_rdy,
  output logic         dec_rst,
  output logic         dec_start,
  output logic [W-1:0] dec_a,
  input  logic         dec_msg,
  output logic         msg_valid,
  output logic         msg_bit,
  output logic         msg_last,
  output logic         msg_id,
  output logic         busy,
  output logic         err_underrun
);

  typedef enum logic [2:0] {IDLE, CLEAR, DSTART, LOAD, WAIT, DRAIN} state_e;

  // Counter is one bit wider than log2(N) so WAIT can count 0..N.
  localparam logic [CNT_W:0] CNT_LAST = (CNT_W+1)'(N - 1);
  localparam logic [CNT_W:0] CNT_WAIT = (CNT_W+1)'(N);

  state_e         state_q;
  logic [CNT_W:0] cnt_q;
  logic           rr_q;      // lane that wins when both request
  logic [1:0]     grant_q;
  logic           gid_q;     // granted lane id
  logic           err_q;

  logic pick_d;
  logic vld_g;

  assign pick_d = (req == 2'b11) ? rr_q : req[1];
  assign vld_g  = gid_q ? coef_vld[1] : coef_vld[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      grant_q <= 2'b00;
      gid_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          gid_q   <= pick_d;
          grant_q <= pick_d ? 2'b10 : 2'b01;
          state_q <= CLEAR;
        end
        CLEAR:  state_q <= DSTART;
        DSTART: begin
          cnt_q   <= '0;
          state_q <= LOAD;
        end
        LOAD: begin
          // The decoder samples every cycle, so a missing coefficient is
          // only flagged, never stalled on.
          if (!vld_g) err_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          // N+1 cycles: decoder compute plus its output register.
          if (cnt_q == CNT_WAIT) begin
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            grant_q <= 2'b00;
            rr_q    <= ~gid_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only (plus the coefficient mux).
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign coef_rdy     = (state_q == LOAD) ? grant_q : 2'b00;
  assign dec_a        = (state_q == LOAD) ? (gid_q ? coef_in1 : coef_in0) : '0;
  assign dec_start    = (state_q == DSTART);
  assign dec_rst      = !reset || (state_q == CLEAR);
  assign msg_valid    = (state_q == DRAIN);
  assign msg_bit      = (state_q == DRAIN) && dec_msg;
  assign msg_last     = (state_q == DRAIN) && (cnt_q == CNT_LAST);
  assign msg_id       = (state_q == DRAIN) && gid_q;
  assign err_underrun = err_q;

endmodule
